// File: rtl/tbuf_bus_sequencer_pkg.sv
// +----------------------------------------------------------------------------+
// | tbuf_pkg: shared state encoding, reset constants and width helpers         |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

package tbuf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DEAD  = 2'd1,
    DRIVE = 2'd2
  } state_t;

  localparam logic C_OE_RST      = 1'b0;
  localparam logic C_Y_RST_BIT   = 1'b0;
  localparam logic C_GNT_RST_BIT = 1'b0;

  function automatic int ptr_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Counters must hold values 0..maxv inclusive.
  function automatic int cnt_w(input int maxv);
    return (maxv < 1) ? 1 : $clog2(maxv + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/tbuf_bus_sequencer_if.sv
// +----------------------------------------------------------------------------+
// | tbuf_bus_sequencer_if: requester/bus-side bundle of the bus sequencer      |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

interface tbuf_bus_sequencer_if #(
  parameter int W  = 4,
  parameter int CH = 4
);
  logic [CH-1:0]   req;
  logic [CH*W-1:0] a;
  logic [W-1:0]    y;
  logic            oe;
  logic            oe_bar;
  logic [CH-1:0]   gnt;
  logic            busy;
  logic            preempt;

  modport master (output req, a, input y, oe, oe_bar, gnt, busy, preempt);
  modport slave  (input req, a, output y, oe, oe_bar, gnt, busy, preempt);
endinterface

`default_nettype wire

// File: rtl/tbuf_bus_sequencer_rr_arbiter.sv
// +----------------------------------------------------------------------------+
// | tbuf_rr_arbiter: combinational round-robin pick starting at ptr            |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module tbuf_rr_arbiter
  import tbuf_pkg::*;
#(
  parameter  int CH = 4,
  localparam int PW = ptr_w(CH)
) (
  input  logic [CH-1:0] req,
  input  logic [PW-1:0] ptr,
  input  logic [CH-1:0] excl,
  output logic [CH-1:0] gnt,
  output logic          valid
);

  logic [PW-1:0] w_idx;

  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    w_idx = '0;
    for (int i = 0; i < CH; i++) begin
      w_idx = PW'((int'(ptr) + i) % CH);
      if (!valid && req[w_idx] && !excl[w_idx]) begin
        gnt[w_idx] = 1'b1;
        valid      = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/tbuf_bus_sequencer.sv
// +----------------------------------------------------------------------------+
// | tbuf_bus_sequencer: round-robin owner of a shared tri-state bus with dead  |
// | time and bounded hold. Option macro: TBUF_KEEPER_EN.  Rev 1.0              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tbuf_bus_sequencer
  import tbuf_pkg::*;
#(
  parameter int W        = 4,
  parameter int CH       = 4,
  parameter int DEAD_CYC = 1,
  parameter int MAX_HOLD = 16
) (
  input  logic                 clk,
  input  logic                 rn,
  tbuf_bus_sequencer_if.slave  bus
);

  localparam int PW = ptr_w(CH);
  localparam int DW = cnt_w(DEAD_CYC);
  localparam int HW = cnt_w(MAX_HOLD);

  state_t        r_state;
  logic [CH-1:0] r_gnt;
  logic [PW-1:0] r_owner;
  logic [PW-1:0] r_ptr;
  logic [DW-1:0] r_dead;
  logic [HW-1:0] r_hold;
  logic          r_oe;
  logic          r_preempt;
  logic [W-1:0]  r_y;

  logic [CH-1:0] w_win_gnt;
  logic          w_win_valid;
  logic [PW-1:0] w_win_idx;
  logic [PW-1:0] w_next_ptr;
  logic [PW-1:0] w_arb_ptr;
  logic [W-1:0]  w_a_sel;
  logic [W-1:0]  w_y_off;
  logic          w_owner_req;
  logic          w_others;
  logic          w_forced;
  logic          w_release;

  assign w_owner_req = bus.req[r_owner];
  assign w_others    = |(bus.req & ~r_gnt);
  assign w_forced    = (MAX_HOLD != 0) && (r_hold == HW'(MAX_HOLD)) && w_owner_req && w_others;
  assign w_release   = !w_owner_req || w_forced;
  assign w_next_ptr  = (r_owner == PW'(CH - 1)) ? '0 : r_owner + 1'b1;
  // A release arbitrates from the already-advanced pointer so the old owner goes last.
  assign w_arb_ptr   = (r_state == DRIVE) ? w_next_ptr : r_ptr;

`ifdef TBUF_KEEPER_EN
  assign w_y_off = r_y;
`else
  assign w_y_off = '0;
`endif

  tbuf_rr_arbiter #(.CH(CH)) u_arb (
    .req   (bus.req),
    .ptr   (w_arb_ptr),
    .excl  (r_gnt),
    .gnt   (w_win_gnt),
    .valid (w_win_valid)
  );

  always_comb begin
    w_win_idx = '0;
    w_a_sel   = '0;
    for (int i = 0; i < CH; i++) begin
      if (w_win_gnt[i]) w_win_idx = PW'(i);
      if (r_owner == PW'(i)) w_a_sel = bus.a[i*W +: W];
    end
  end

  always_ff @(posedge clk) begin
    if (!rn) begin
      r_state   <= IDLE;
      r_gnt     <= {CH{C_GNT_RST_BIT}};
      r_owner   <= '0;
      r_ptr     <= '0;
      r_dead    <= '0;
      r_hold    <= '0;
      r_oe      <= C_OE_RST;
      r_preempt <= 1'b0;
      r_y       <= {W{C_Y_RST_BIT}};
    end else begin
      r_preempt <= 1'b0;
      case (r_state)
        IDLE: begin
          r_oe <= 1'b0;
          r_y  <= w_y_off;
          if (w_win_valid) begin
            r_gnt   <= w_win_gnt;
            r_owner <= w_win_idx;
            r_dead  <= DW'(DEAD_CYC);
            r_state <= DEAD;
          end
        end
        DEAD: begin
          r_oe <= 1'b0;
          r_y  <= w_y_off;
          if (!w_owner_req) begin
            if (w_win_valid) begin
              r_gnt   <= w_win_gnt;
              r_owner <= w_win_idx;
              r_dead  <= DW'(DEAD_CYC);
            end else begin
              r_gnt   <= '0;
              r_state <= IDLE;
            end
          end else if (r_dead <= DW'(1)) begin
            r_dead  <= '0;
            r_hold  <= '0;
            r_oe    <= 1'b1;
            r_y     <= w_a_sel;
            r_state <= DRIVE;
          end else begin
            r_dead <= r_dead - 1'b1;
          end
        end
        DRIVE: begin
          if (w_release) begin
            r_oe      <= 1'b0;
            r_hold    <= '0;
            r_ptr     <= w_next_ptr;
            r_preempt <= w_forced;
            r_y       <= w_y_off;
            if (w_win_valid) begin
              r_gnt   <= w_win_gnt;
              r_owner <= w_win_idx;
              r_dead  <= DW'(DEAD_CYC);
              r_state <= DEAD;
            end else begin
              r_gnt   <= '0;
              r_state <= IDLE;
            end
          end else begin
            r_y <= w_a_sel;
            if (r_hold != HW'(MAX_HOLD)) r_hold <= r_hold + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_gnt   <= '0;
          r_oe    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.y       = r_y;
  assign bus.oe      = r_oe;
  assign bus.oe_bar  = ~r_oe;
  assign bus.gnt     = r_gnt;
  assign bus.busy    = (r_state != IDLE);
  assign bus.preempt = r_preempt;

endmodule

`default_nettype wire

// File: tb/tb_tbuf_bus_sequencer.sv
// +----------------------------------------------------------------------------+
// | tb_tbuf_bus_sequencer: directed stimulus with queued expectations         |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_tbuf_bus_sequencer;

  logic clk = 1'b0;
  logic rn  = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  bit   end_chk = 1'b0;
  bit   end_done = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tbuf_bus_sequencer_if #(.W(4), .CH(4)) bus0 ();
  tbuf_bus_sequencer_if #(.W(4), .CH(4)) bus1 ();

  tbuf_bus_sequencer #(.W(4), .CH(4), .DEAD_CYC(1), .MAX_HOLD(4)) u0 (
    .clk (clk),
    .rn  (rn),
    .bus (bus0)
  );

  tbuf_bus_sequencer #(.W(4), .CH(4), .DEAD_CYC(3), .MAX_HOLD(4)) u1 (
    .clk (clk),
    .rn  (rn),
    .bus (bus1)
  );

  typedef struct {
    int          cyc;
    int          dut;
    string       name;
    logic [3:0]  gnt;
    logic        oe;
    logic [3:0]  y;
    logic        busy;
    logic        pre;
  } exp_t;

  exp_t q[$];
  exp_t me;
  logic [3:0] got_gnt, got_y;
  logic       got_oe, got_oe_bar, got_busy, got_pre;
  logic [3:0] prev_gnt [2] = '{4'h0, 4'h0};

  function automatic logic [3:0] yoff(input logic [3:0] last);
`ifdef TBUF_KEEPER_EN
    return last;
`else
    return 4'h0;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int dut, input string name, input logic [3:0] g,
                          input logic o, input logic [3:0] yv, input logic b, input logic p);
    exp_t e;
    e.cyc = cyc; e.dut = dut; e.name = name;
    e.gnt = g; e.oe = o; e.y = yv; e.busy = b; e.pre = p;
    q.push_back(e);
  endtask

  task automatic do_reset();
    rn = 1'b0;
    bus0.req = 4'hF; bus1.req = 4'hF;
    bus0.a = 16'hFFFF; bus1.a = 16'hFFFF;
    step();
    push_exp(0, "reset_dut0", 4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
    push_exp(1, "reset_dut1", 4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
    rn = 1'b1;
    bus0.req = 4'h0; bus1.req = 4'h0;
    bus0.a = 16'hC5A3; bus1.a = 16'hC5A3;
  endtask

  // Monitor: scoreboard pops plus per-cycle bus invariants.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      me = q.pop_front();
      got_gnt  = (me.dut == 0) ? bus0.gnt     : bus1.gnt;
      got_oe   = (me.dut == 0) ? bus0.oe      : bus1.oe;
      got_y    = (me.dut == 0) ? bus0.y       : bus1.y;
      got_busy = (me.dut == 0) ? bus0.busy    : bus1.busy;
      got_pre  = (me.dut == 0) ? bus0.preempt : bus1.preempt;
      tests++;
      if (me.cyc != cyc) begin
        fails++;
        $display("FAIL %s: checked at cycle %0d, required cycle %0d", me.name, cyc, me.cyc);
      end else if ({got_gnt, got_oe, got_y, got_busy, got_pre} !==
                   {me.gnt, me.oe, me.y, me.busy, me.pre}) begin
        fails++;
        $display("FAIL %s @%0d: got gnt=%b oe=%b y=%h busy=%b pre=%b, want gnt=%b oe=%b y=%h busy=%b pre=%b",
                 me.name, cyc, got_gnt, got_oe, got_y, got_busy, got_pre,
                 me.gnt, me.oe, me.y, me.busy, me.pre);
      end
    end
    if (cyc >= 1) begin
      for (int d = 0; d < 2; d++) begin
        got_gnt    = (d == 0) ? bus0.gnt    : bus1.gnt;
        got_oe     = (d == 0) ? bus0.oe     : bus1.oe;
        got_oe_bar = (d == 0) ? bus0.oe_bar : bus1.oe_bar;
        tests++;
        if (got_oe_bar !== ~got_oe || !$onehot0(got_gnt) ||
            (got_gnt !== prev_gnt[d] && got_oe !== 1'b0)) begin
          fails++;
          $display("FAIL inv_dut%0d @%0d: got gnt=%b oe=%b oe_bar=%b prev_gnt=%b, want oe_bar=~oe, gnt one-hot/zero, oe=0 on gnt change",
                   d, cyc, got_gnt, got_oe, got_oe_bar, prev_gnt[d]);
        end
        prev_gnt[d] = got_gnt;
      end
    end
    if (end_chk && !end_done) begin
      end_done = 1'b1;
      tests++;
      if (q.size() != 0) begin
        fails++;
        $display("FAIL drain: got %0d unchecked expectations, want 0", q.size());
      end
    end
  end

  initial begin
    bus0.req = 4'h0; bus1.req = 4'h0;
    bus0.a = 16'h0;  bus1.a = 16'h0;

    // Reset with every request asserted
    do_reset();

    // Single requester: grant, one dead cycle, drive, release
    bus0.req = 4'b0010;
    step(); push_exp(0, "t2_grant",   4'b0010, 1'b0, 4'h0, 1'b1, 1'b0);
    step(); push_exp(0, "t2_drive",   4'b0010, 1'b1, 4'hA, 1'b1, 1'b0);
    bus0.req = 4'b0000;
    step(); push_exp(0, "t2_release", 4'b0000, 1'b0, yoff(4'hA), 1'b0, 1'b0);
    step(); push_exp(0, "t2_idle",    4'b0000, 1'b0, yoff(4'hA), 1'b0, 1'b0);

    // Handover ch0 -> ch2 with dead time
    do_reset();
    bus0.req = 4'b0101;
    step(); push_exp(0, "t3_grant0",   4'b0001, 1'b0, 4'h0, 1'b1, 1'b0);
    step(); push_exp(0, "t3_drive0",   4'b0001, 1'b1, 4'h3, 1'b1, 1'b0);
    step(); push_exp(0, "t3_hold0",    4'b0001, 1'b1, 4'h3, 1'b1, 1'b0);
    bus0.req = 4'b0100;
    step(); push_exp(0, "t3_handover", 4'b0100, 1'b0, yoff(4'h3), 1'b1, 1'b0);
    step(); push_exp(0, "t3_drive2",   4'b0100, 1'b1, 4'h5, 1'b1, 1'b0);
    bus0.req = 4'b0000;
    step(); push_exp(0, "t3_idle",     4'b0000, 1'b0, yoff(4'h5), 1'b0, 1'b0);

    // Forced release after MAX_HOLD hold cycles
    do_reset();
    bus0.req = 4'b0010;
    step(); push_exp(0, "t4_grant1", 4'b0010, 1'b0, 4'h0, 1'b1, 1'b0);
    step(); push_exp(0, "t4_drive1", 4'b0010, 1'b1, 4'hA, 1'b1, 1'b0);
    bus0.req = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      step(); push_exp(0, "t4_hold1", 4'b0010, 1'b1, 4'hA, 1'b1, 1'b0);
    end
    step(); push_exp(0, "t4_preempt", 4'b1000, 1'b0, yoff(4'hA), 1'b1, 1'b1);
    step(); push_exp(0, "t4_drive3",  4'b1000, 1'b1, 4'hC, 1'b1, 1'b0);
    bus0.req = 4'b0000;
    step(); push_exp(0, "t4_idle",    4'b0000, 1'b0, yoff(4'hC), 1'b0, 1'b0);

    // Lone requester never preempted; saturated hold preempts at once, wrap to ch0
    do_reset();
    bus0.req = 4'b0010;
    step(); push_exp(0, "t4b_grant1", 4'b0010, 1'b0, 4'h0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      bus0.a[7:4] = 4'(i);
      step(); push_exp(0, "t4b_lone", 4'b0010, 1'b1, 4'(i), 1'b1, 1'b0);
    end
    bus0.req = 4'b0011;
    step(); push_exp(0, "t4b_preempt", 4'b0001, 1'b0, yoff(4'h7), 1'b1, 1'b1);
    step(); push_exp(0, "t4b_drive0",  4'b0001, 1'b1, 4'h3, 1'b1, 1'b0);

    // Reset in the middle of DRIVE
    rn = 1'b0;
    step(); push_exp(0, "t6_mid_reset", 4'b0000, 1'b0, 4'h0, 1'b0, 1'b0);
    rn = 1'b1;
    bus0.req = 4'b0000;

    // Re-arbitration during a 3-cycle dead window
    bus1.a = 16'hC5A3;
    bus1.req = 4'b0100;
    step(); push_exp(1, "t5_grant2",   4'b0100, 1'b0, 4'h0, 1'b1, 1'b0);
    bus1.req = 4'b0001;
    step(); push_exp(1, "t5_regrant0", 4'b0001, 1'b0, 4'h0, 1'b1, 1'b0);
    step(); push_exp(1, "t5_dead_a",   4'b0001, 1'b0, 4'h0, 1'b1, 1'b0);
    step(); push_exp(1, "t5_dead_b",   4'b0001, 1'b0, 4'h0, 1'b1, 1'b0);
    step(); push_exp(1, "t5_drive0",   4'b0001, 1'b1, 4'h3, 1'b1, 1'b0);
    bus1.req = 4'b0000;
    step(); push_exp(1, "t5_idle",     4'b0000, 1'b0, yoff(4'h3), 1'b0, 1'b0);

    step();
    end_chk = 1'b1;
    step();
    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
